// File: rtl/delay_meas_if.sv
// Run-control and result bus between a host and delay_meas_ctrl.
// The host drives start/abort; the controller returns status and statistics.
interface delay_meas_if;
   logic        start;
   logic        abort;
   logic        busy;
   logic        done;
   logic        timeout;
   logic        sample_valid;
   logic [31:0] sample;
   logic [39:0] sum;
   logic [31:0] min_s;
   logic [31:0] max_s;

   modport master (
      output start, abort,
      input  busy, done, timeout, sample_valid, sample, sum, min_s, max_s
   );

   modport slave (
      input  start, abort,
      output busy, done, timeout, sample_valid, sample, sum, min_s, max_s
   );
endinterface

// File: rtl/delay_meas_ctrl.sv
// Propagation-delay measurement sequencer: toggles a launch level into a path,
// times the synchronized return against a free-running datapath counter.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no run; start clears statistics and begins a run
// LAUNCH  | snapshot counter into t0, toggle pathInput
// WAIT    | counter enabled; wait for synchronized edge or timeout
// CAPTURE | record modular delay, update sum/min/max/count
// GAP     | settle down-counter between measurements
// FIN     | one-cycle done strobe
module delay_meas_ctrl #(
   parameter int unsigned SAMPLES = 16,
   parameter int unsigned TIMEOUT = 65535,
   parameter int unsigned SETTLE  = 8,
   parameter bit          INVERT  = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   delay_meas_if.slave  ctl,
   output logic         pathInput,
   input  logic         pathResult,
   output logic         ld,
   input  logic [31:0]  result
);

   localparam logic [7:0]  SAMPLES_C = SAMPLES[7:0];
   localparam logic [7:0]  SETTLE_C  = SETTLE[7:0];
   localparam logic [31:0] TIMEOUT_C = TIMEOUT[31:0];

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_CAPTURE,
      S_GAP,
      S_FIN
   } state_t;

   state_t      state_q, state_d;
   logic        psync1_q, psync1_d;
   logic        psync_q, psync_d;
   logic        path_in_q, path_in_d;
   logic        expected_q, expected_d;
   logic [31:0] t0_q, t0_d;
   logic [31:0] sample_q, sample_d;
   logic        sample_valid_q, sample_valid_d;
   logic [39:0] sum_q, sum_d;
   logic [31:0] min_q, min_d;
   logic [31:0] max_q, max_d;
   logic        timeout_q, timeout_d;
   logic [7:0]  count_q, count_d;
   logic [7:0]  gap_q, gap_d;

   logic [31:0] elapsed;
   logic [7:0]  count_inc;
   logic        busy;

   // Modular difference keeps counter wrap-around invisible.
   assign elapsed   = result - t0_q;
   assign count_inc = count_q + 8'd1;
   assign busy      = (state_q != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         psync1_q       <= INVERT;
         psync_q        <= INVERT;
         path_in_q      <= 1'b0;
         expected_q     <= 1'b0;
         t0_q           <= '0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         sum_q          <= '0;
         min_q          <= '1;
         max_q          <= '0;
         timeout_q      <= 1'b0;
         count_q        <= '0;
         gap_q          <= '0;
      end else begin
         state_q        <= state_d;
         psync1_q       <= psync1_d;
         psync_q        <= psync_d;
         path_in_q      <= path_in_d;
         expected_q     <= expected_d;
         t0_q           <= t0_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
         sum_q          <= sum_d;
         min_q          <= min_d;
         max_q          <= max_d;
         timeout_q      <= timeout_d;
         count_q        <= count_d;
         gap_q          <= gap_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      psync1_d       = pathResult;
      psync_d        = psync1_q;
      path_in_d      = path_in_q;
      expected_d     = expected_q;
      t0_d           = t0_q;
      sample_d       = sample_q;
      sample_valid_d = 1'b0;
      sum_d          = sum_q;
      min_d          = min_q;
      max_d          = max_q;
      timeout_d      = timeout_q;
      count_d        = count_q;
      gap_d          = gap_q;

      // Abort wins over every busy-state action; all results simply hold.
      if (ctl.abort && busy) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ctl.start && !ctl.abort) begin
                  state_d   = S_LAUNCH;
                  sum_d     = '0;
                  count_d   = '0;
                  timeout_d = 1'b0;
                  min_d     = '1;
                  max_d     = '0;
               end
            end
            S_LAUNCH: begin
               t0_d       = result;
               path_in_d  = ~path_in_q;
               expected_d = ~path_in_q ^ INVERT;
               state_d    = S_WAIT;
            end
            S_WAIT: begin
               if (psync_q == expected_q) begin
                  state_d = S_CAPTURE;
               end else if (elapsed >= TIMEOUT_C) begin
                  timeout_d = 1'b1;
                  state_d   = S_FIN;
               end
            end
            S_CAPTURE: begin
               sample_d       = elapsed;
               sample_valid_d = 1'b1;
               sum_d          = sum_q + {8'd0, elapsed};
               if (elapsed < min_q) min_d = elapsed;
               if (elapsed > max_q) max_d = elapsed;
               count_d = count_inc;
               if (count_inc == SAMPLES_C) begin
                  state_d = S_FIN;
               end else begin
                  gap_d   = SETTLE_C - 8'd1;
                  state_d = S_GAP;
               end
            end
            S_GAP: begin
               if (gap_q == 8'd0) begin
                  state_d = S_LAUNCH;
               end else begin
                  gap_d = gap_q - 8'd1;
               end
            end
            S_FIN: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign pathInput        = path_in_q;
   assign ld               = (state_q == S_WAIT);
   assign ctl.busy         = busy;
   assign ctl.done         = (state_q == S_FIN);
   assign ctl.timeout      = timeout_q;
   assign ctl.sample       = sample_q;
   assign ctl.sample_valid = sample_valid_q;
   assign ctl.sum          = sum_q;
   assign ctl.min_s        = min_q;
   assign ctl.max_s        = max_q;

endmodule

// File: tb/tb_delay_meas_ctrl.sv
// Directed bench for delay_meas_ctrl: counter and delay-path models around the DUT,
// hand-computed expected samples for each path configuration.
module tb_delay_meas_ctrl;
   localparam int SAMPLES = 4;
   localparam int TIMEOUT = 20;
   localparam int SETTLE  = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        path_in;
   logic        path_res;
   logic        ld;
   logic [31:0] cnt = '0;
   logic        cnt_load = 1'b0;
   logic [31:0] cnt_load_val = '0;
   logic [31:0] dly_line = '0;
   int          path_mode = 0;
   int          path_dly = 1;

   int n_assert = 0;
   int n_fail   = 0;

   int sv_cnt = 0, done_cnt = 0, done_sv_cnt = 0, tog_cnt = 0, ld_cnt = 0;
   int b_sv, b_done, b_done_sv, b_tog, b_ld, b_samp;
   logic        path_prev = 1'b0;
   logic [31:0] samp_q[$];

   always #5 clk = ~clk;

   delay_meas_if ctl();

   delay_meas_ctrl #(
      .SAMPLES (SAMPLES),
      .TIMEOUT (TIMEOUT),
      .SETTLE  (SETTLE),
      .INVERT  (1'b0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ctl        (ctl.slave),
      .pathInput  (path_in),
      .pathResult (path_res),
      .ld         (ld),
      .result     (cnt)
   );

   // Datapath counter and registered delay line
   always @(posedge clk) begin
      dly_line <= {dly_line[30:0], path_in};
      if (cnt_load)  cnt <= cnt_load_val;
      else if (ld)   cnt <= cnt + 32'd1;
   end

   always_comb begin
      case (path_mode)
         0:       path_res = path_in;
         1:       path_res = dly_line[path_dly-1];
         default: path_res = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (ctl.sample_valid) begin
            sv_cnt++;
            samp_q.push_back(ctl.sample);
         end
         if (ctl.done) begin
            done_cnt++;
            if (ctl.sample_valid) done_sv_cnt++;
         end
         if (path_in !== path_prev) tog_cnt++;
         if (ld) ld_cnt++;
      end
      path_prev = path_in;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_cnt(input logic [31:0] v);
      @(negedge clk);
      cnt_load = 1'b1;
      cnt_load_val = v;
      @(negedge clk);
      cnt_load = 1'b0;
   endtask

   task automatic snap();
      b_sv = sv_cnt; b_done = done_cnt; b_done_sv = done_sv_cnt;
      b_tog = tog_cnt; b_ld = ld_cnt; b_samp = samp_q.size();
   endtask

   task automatic pulse_start();
      @(negedge clk);
      ctl.start = 1'b1;
      @(negedge clk);
      ctl.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k = 0;
      while (ctl.done !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_done_seen"}, ctl.done, 1);
      @(negedge clk);
   endtask

   task automatic wait_ld_rises(input int n, input int budget, output int got);
      logic prev = 1'b0;
      got = 0;
      for (int k = 0; k < budget && got < n; k++) begin
         @(negedge clk);
         if (ld && !prev) got++;
         prev = ld;
      end
   endtask

   task automatic run_check(input string tag, input int exp_s, input int n);
      chk({tag, "_nsv"},   sv_cnt - b_sv, n);
      chk({tag, "_ndone"}, done_cnt - b_done, 1);
      chk({tag, "_done_at_last"}, done_sv_cnt - b_done_sv, 1);
      chk({tag, "_toggles"}, tog_cnt - b_tog, n);
      chk({tag, "_ld_cycles"}, ld_cnt - b_ld, exp_s * n);
      for (int i = b_samp; i < samp_q.size(); i++)
         chk({tag, "_sample"}, samp_q[i], exp_s);
      chk({tag, "_sum"}, ctl.sum, exp_s * n);
      chk({tag, "_min"}, ctl.min_s, exp_s);
      chk({tag, "_max"}, ctl.max_s, exp_s);
      chk({tag, "_timeout"}, ctl.timeout, 0);
      chk({tag, "_busy"}, ctl.busy, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"},  ctl.busy, 0);
      chk({tag, "_pin"},   path_in, 0);
      chk({tag, "_ld"},    ld, 0);
      chk({tag, "_sample"}, ctl.sample, 0);
      chk({tag, "_sv"},    ctl.sample_valid, 0);
      chk({tag, "_sum"},   ctl.sum, 0);
      chk({tag, "_min"},   ctl.min_s, 32'hFFFF_FFFF);
      chk({tag, "_max"},   ctl.max_s, 0);
      chk({tag, "_done"},  ctl.done, 0);
      chk({tag, "_tmo"},   ctl.timeout, 0);
   endtask

   initial begin
      int got;
      logic pin_hold;
      int ld_before;

      ctl.start = 1'b0;
      ctl.abort = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("rst");
      idle(2);
      rst_n = 1'b1;
      idle(3);

      // Zero-delay path: latency is the synchronizer only
      path_mode = 0;
      load_cnt(32'd100);
      snap();
      pulse_start();
      wait_done("a", 200);
      run_check("a", 3, SAMPLES);

      // 5-cycle registered path, plus a start while busy
      path_mode = 1; path_dly = 5;
      idle(10);
      snap();
      pulse_start();
      idle(8);
      chk("b_busy_mid", ctl.busy, 1);
      pulse_start();
      wait_done("b", 300);
      run_check("b", 8, SAMPLES);

      // Counter wraps through zero during the first measurement
      path_dly = 2;
      idle(10);
      load_cnt(32'hFFFF_FFFE);
      snap();
      pulse_start();
      wait_done("c", 200);
      run_check("c", 5, SAMPLES);

      // Path never responds
      path_mode = 2;
      idle(5);
      snap();
      pulse_start();
      wait_done("d", 200);
      chk("d_ld_cycles", ld_cnt - b_ld, 21);
      chk("d_nsv", sv_cnt - b_sv, 0);
      chk("d_ndone", done_cnt - b_done, 1);
      chk("d_timeout", ctl.timeout, 1);
      chk("d_sample_held", ctl.sample, 5);
      idle(3);
      chk("d_timeout_sticky", ctl.timeout, 1);

      // Match lands in the same WAIT cycle the timeout threshold is reached
      path_mode = 1; path_dly = 18;
      idle(25);
      snap();
      pulse_start();
      wait_done("e", 400);
      run_check("e", 21, SAMPLES);

      // Abort in the second WAIT cycle of the third measurement
      path_dly = 5;
      idle(10);
      snap();
      pulse_start();
      wait_ld_rises(3, 200, got);
      chk("f_rises", got, 3);
      @(negedge clk);
      chk("f_ld_wait2", ld, 1);
      pin_hold = path_in;
      ctl.abort = 1'b1;
      @(negedge clk);
      ctl.abort = 1'b0;
      chk("f_busy", ctl.busy, 0);
      chk("f_ld", ld, 0);
      chk("f_pin_held", path_in, pin_hold);
      chk("f_sum", ctl.sum, 16);
      chk("f_sample", ctl.sample, 8);
      chk("f_min", ctl.min_s, 8);
      chk("f_max", ctl.max_s, 8);
      chk("f_nsv", sv_cnt - b_sv, 2);
      idle(5);
      chk("f_no_done", done_cnt - b_done, 0);
      chk("f_still_idle", ctl.busy, 0);

      // start together with abort while idle
      ld_before = ld_cnt;
      @(negedge clk);
      ctl.start = 1'b1;
      ctl.abort = 1'b1;
      @(negedge clk);
      ctl.start = 1'b0;
      ctl.abort = 1'b0;
      chk("g_busy", ctl.busy, 0);
      idle(3);
      chk("g_busy_later", ctl.busy, 0);
      chk("g_no_ld", ld_cnt - ld_before, 0);

      // Asynchronous reset in the middle of WAIT
      snap();
      pulse_start();
      wait_ld_rises(3, 200, got);
      chk("h_rises", got, 3);
      chk("h_pin_before", path_in, 1);
      chk("h_sum_before", ctl.sum, 16);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("h_rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Fresh run after reset must again see a full set of samples
      path_mode = 0;
      idle(5);
      load_cnt(32'h1234_5678);
      snap();
      pulse_start();
      wait_done("i", 200);
      run_check("i", 3, SAMPLES);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
